// File: rtl/lab3_g29_p5_pkg.sv
// Shared types and sizing constants for the 16-way round-robin arbiter.
package lab3_g29_p5_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/lab3_g29_p5_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping past N-1.
module lab3_g29_p5_rr_pick #(
  parameter int N     = lab3_g29_p5_pkg::N_REQ,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win_idx
);

  // Scan from the farthest offset down so the nearest hit to ptr is written last.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int               j;
      logic [SEL_W-1:0] idx;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = SEL_W'(j);
      if (req[idx]) begin
        any     = 1'b1;
        win_idx = idx;
      end
    end
  end

endmodule

// File: rtl/lab3_g29_p5_rr_arbiter.sv
// Round-robin arbiter with hold limit, one-cycle gap between owners and
// registered active-low one-hot grant.
//
//   state | meaning
//   IDLE  | no grant, waiting for any request
//   GRANT | owner holds the resource, hold_cnt counts cycles held
//   GAP   | one dead cycle after an owner exits, ptr already advanced
module lab3_g29_p5_rr_arbiter #(
  parameter int N        = lab3_g29_p5_pkg::N_REQ,
  parameter int SEL_W    = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt_n,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  import lab3_g29_p5_pkg::*;

  localparam int                HOLD_W    = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]      ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(N - 1);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  owner;
  logic [HOLD_W-1:0] hold_cnt;

  logic              any;
  logic [SEL_W-1:0]  win_idx;
  logic              others_waiting;
  logic [SEL_W-1:0]  next_ptr;

  lab3_g29_p5_rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .any     (any),
    .win_idx (win_idx)
  );

  assign others_waiting = |(req & ~(ONE << owner));
  assign next_ptr       = (owner == LAST_IDX) ? '0 : owner + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      gnt_n     <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any) begin
            state     <= GRANT;
            owner     <= win_idx;
            hold_cnt  <= '0;
            gnt_n     <= ~(ONE << win_idx);
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
          end else begin
            state     <= IDLE;
            gnt_n     <= '1;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          // Release wins over preemption when both apply in the same cycle.
          if (!req[owner] || (hold_cnt == HOLD_LAST && others_waiting)) begin
            state     <= GAP;
            ptr       <= next_ptr;
            gnt_n     <= '1;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= req[owner];
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt_n     <= '1;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_g29_p5_rr_arbiter.sv
// Directed table-driven bench for the round-robin arbiter plus multi-cycle sequences.
module tb_lab3_g29_p5_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic [15:0] gnt_n;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        preempt;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        valid;
    logic [3:0]  idx;
    logic        pre;
  } vec_t;

  vec_t vq[$];

  lab3_g29_p5_rr_arbiter #(
    .N        (16),
    .SEL_W    (4),
    .MAX_HOLD (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [3:0] ei, input logic ep);
    logic [15:0] en;
    logic [15:0] one;
    one = 16'h0001;
    en  = ev ? ~(one << ei) : 16'hFFFF;
    total++;
    if (gnt_n === en && gnt_idx === (ev ? ei : 4'd0) && gnt_valid === ev && preempt === ep)
      passed++;
    else
      $display("FAIL %s: got gnt_n=%h idx=%0d valid=%b preempt=%b, want gnt_n=%h idx=%0d valid=%b preempt=%b",
               name, gnt_n, gnt_idx, gnt_valid, preempt, en, ev ? ei : 4'd0, ev, ep);
  endtask

  task automatic add(input logic r, input logic [15:0] q, input logic v, input logic [3:0] i, input logic p);
    vec_t e;
    e.rst = r; e.req = q; e.valid = v; e.idx = i; e.pre = p;
    vq.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 16'h0000;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 16'h0000;
    step();

    // reset with all requests held, then release
    add(1, 16'hFFFF, 0, 0, 0);
    add(1, 16'hFFFF, 0, 0, 0);
    add(0, 16'hFFFF, 1, 0, 0);
    add(1, 16'h0000, 0, 0, 0);
    // lone request idx 5, release, gap, idle; ptr then 6
    add(0, 16'h0020, 1, 5, 0);
    add(0, 16'h0020, 1, 5, 0);
    add(0, 16'h0020, 1, 5, 0);
    add(0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0);
    add(0, 16'h0041, 1, 6, 0);
    add(0, 16'h0001, 0, 0, 0);
    add(0, 16'h0001, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0);
    // 0444 rotation 2 -> 6 -> 10 -> 2, each owner releasing after 2 cycles
    add(1, 16'h0000, 0, 0, 0);
    add(0, 16'h0444, 1, 2, 0);
    add(0, 16'h0444, 1, 2, 0);
    add(0, 16'h0440, 0, 0, 0);
    add(0, 16'h0440, 1, 6, 0);
    add(0, 16'h0440, 1, 6, 0);
    add(0, 16'h0404, 0, 0, 0);
    add(0, 16'h0404, 1, 10, 0);
    add(0, 16'h0404, 1, 10, 0);
    add(0, 16'h0004, 0, 0, 0);
    add(0, 16'h0004, 1, 2, 0);
    add(0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0);

    foreach (vq[k]) begin
      reset = vq[k].rst;
      req   = vq[k].req;
      step();
      check($sformatf("vec%0d", k), vq[k].valid, vq[k].idx, vq[k].pre);
    end

    // two contenders: 8 cycles each, preempting gap, period 18
    do_reset();
    req = 16'h8001;
    for (int t = 0; t < 40; t++) begin
      int ph;
      step();
      ph = t % 18;
      if (ph < 8)       check($sformatf("hold8001_t%0d", t), 1'b1, 4'd0, 1'b0);
      else if (ph == 8) check($sformatf("hold8001_t%0d", t), 1'b0, 4'd0, 1'b1);
      else if (ph < 17) check($sformatf("hold8001_t%0d", t), 1'b1, 4'd15, 1'b0);
      else              check($sformatf("hold8001_t%0d", t), 1'b0, 4'd0, 1'b1);
    end

    // lone requester is never preempted
    do_reset();
    req = 16'h0100;
    for (int t = 0; t < 40; t++) begin
      step();
      check($sformatf("lone_t%0d", t), 1'b1, 4'd8, 1'b0);
    end

    // release coinciding with hold limit is a plain release
    do_reset();
    req = 16'h0003;
    for (int t = 0; t < 8; t++) begin
      step();
      check($sformatf("relpre_hold_t%0d", t), 1'b1, 4'd0, 1'b0);
    end
    req = 16'h0002;
    step();
    check("relpre_gap", 1'b0, 4'd0, 1'b0);
    step();
    check("relpre_next", 1'b1, 4'd1, 1'b0);

    // owner re-raising in the gap loses to the other requester
    req = 16'h0003;
    step();
    check("reraise_hold", 1'b1, 4'd1, 1'b0);
    req = 16'h0001;
    step();
    check("reraise_gap", 1'b0, 4'd0, 1'b0);
    req = 16'h0003;
    step();
    check("reraise_win", 1'b1, 4'd0, 1'b0);

    // reset mid-grant to idx 7 drops grant and returns ptr to 0
    do_reset();
    req = 16'h0040;
    step();
    check("mid_pre6", 1'b1, 4'd6, 1'b0);
    req = 16'h0000;
    step();
    step();
    check("mid_idle", 1'b0, 4'd0, 1'b0);
    req = 16'h0080;
    for (int t = 0; t < 3; t++) begin
      step();
      check($sformatf("mid_g7_t%0d", t), 1'b1, 4'd7, 1'b0);
    end
    reset = 1'b1;
    step();
    check("mid_reset", 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    req   = 16'h0081;
    step();
    check("mid_after", 1'b1, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
